cv32e40s_wpt_tagged: RTL and testbench

Parametrised watchpoint-trigger stage between the load/store unit and the MPU interface, with configurable trigger count. Triggers classed "before" consume the matching transfer and return a synthetic response once all in-flight bus transactions drain. Triggers classed "after" let the transfer reach the bus and tag its response with the match bits. It tracks outstanding transactions internally through a counter and a per-transaction tag FIFO; the core supplies no pending-transaction hint.

---
 rtl/cv32e40s_pkg.sv | 41 ++++
 rtl/cv32e40s_wpt_tag_fifo.sv | 58 +++++
 rtl/cv32e40s_wpt_tagged.sv | 131 +++++++++++++
 tb/tb_cv32e40s_wpt_tagged.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the load/store path: watchpoint FSM states, OBI data request and core response.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    WPT_IDLE,
    WPT_WAIT,
    WPT_RESP
  } wpt_state_e;

  typedef enum logic [1:0] {
    MPU_OK,
    MPU_RE_FAULT,
    MPU_WR_FAULT
  } mpu_status_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
    logic [2:0]  prot;
    logic [1:0]  memtype;
    logic        dbg;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        exokay;
  } obi_data_resp_t;

  typedef struct packed {
    obi_data_resp_t bus_resp;
    mpu_status_e    mpu_status;
    logic [31:0]    wpt_match;
  } data_resp_t;

  localparam int WPT_MATCH_W = 32;

endpackage

// File: rtl/cv32e40s_wpt_tag_fifo.sv
// Small register FIFO holding the after-trigger match bits of each in-flight bus transfer.
module cv32e40s_wpt_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_en  = pop && !empty;
  // A pop in the same cycle frees the slot the push writes into.
  assign push_en = push && (!full || pop_en);
  assign rdata   = mem[rd_ptr_q];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (push_en && (wr_ptr_q == PW'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      cnt_q <= cnt_q + CW'(1);
      else if (!push_en && pop_en) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/cv32e40s_wpt_tagged.sv
// Watchpoint stage between LSU and MPU: "before" hits are consumed and answered synthetically,
// "after" hits travel with the transfer and are returned as a tag on its bus response.
module cv32e40s_wpt_tagged
  import cv32e40s_pkg::*;
#(
  parameter int DBG_NUM_TRIGGERS = 1,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DBG_NUM_TRIGGERS-1:0]            trigger_match_i,
  input  logic [DBG_NUM_TRIGGERS-1:0]            trigger_after_i,
  input  logic                                   core_trans_valid_i,
  output logic                                   core_trans_ready_o,
  input  obi_data_req_t                          core_trans_i,
  input  logic                                   core_trans_pushpop_i,
  output logic                                   core_resp_valid_o,
  output data_resp_t                             core_resp_o,
  output logic                                   mpu_trans_valid_o,
  input  logic                                   mpu_trans_ready_i,
  output obi_data_req_t                          mpu_trans_o,
  output logic                                   mpu_trans_pushpop_o,
  input  logic                                   mpu_resp_valid_i,
  input  data_resp_t                             mpu_resp_i,
  input  logic                                   core_wpt_wait_i,
  output logic [31:0]                            core_wpt_match_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  wpt_state_e       state_q, state_next;
  logic [31:0]      before_hit, after_hit, match_q;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             consume, full, bus_fire, resp_pop;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_rdata;

  assign before_hit = WPT_MATCH_W'(trigger_match_i & ~trigger_after_i);
  assign after_hit  = WPT_MATCH_W'(trigger_match_i & trigger_after_i);

  assign core_wpt_match_o    = WPT_MATCH_W'(trigger_match_i);
  assign mpu_trans_o         = core_trans_i;
  assign mpu_trans_pushpop_o = core_trans_pushpop_i;
  assign outstanding_cnt_o   = cnt_q;

  assign consume  = (state_q == WPT_IDLE) && core_trans_valid_i && (|before_hit);
  assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING)) || fifo_full;
  assign bus_fire = mpu_trans_valid_o && mpu_trans_ready_i;
  // A response with nothing in flight is ignored so the counter and FIFO cannot underflow.
  assign resp_pop = mpu_resp_valid_i && (cnt_q != '0);

  always_comb begin
    cnt_next = cnt_q;
    if (bus_fire && !resp_pop)      cnt_next = cnt_q + CNT_W'(1);
    else if (!bus_fire && resp_pop) cnt_next = cnt_q - CNT_W'(1);
  end

  cv32e40s_wpt_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (WPT_MATCH_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus_fire),
    .pop   (resp_pop),
    .wdata (after_hit),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WPT_IDLE;
      cnt_q   <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      if (consume)                    match_q <= before_hit;
      else if (state_q == WPT_RESP)   match_q <= '0;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      WPT_IDLE: begin
        if (consume && core_wpt_wait_i) begin
          state_next = (cnt_next == '0) ? WPT_RESP : WPT_WAIT;
        end
      end
      WPT_WAIT: begin
        if (cnt_next == '0) state_next = WPT_RESP;
      end
      WPT_RESP: state_next = WPT_IDLE;
      default:  state_next = WPT_IDLE;
    endcase
  end

  always_comb begin
    core_trans_ready_o           = 1'b0;
    mpu_trans_valid_o            = 1'b0;
    core_resp_valid_o            = mpu_resp_valid_i;
    core_resp_o.bus_resp         = mpu_resp_i.bus_resp;
    core_resp_o.mpu_status       = mpu_resp_i.mpu_status;
    core_resp_o.wpt_match        = fifo_empty ? '0 : fifo_rdata;
    case (state_q)
      WPT_IDLE: begin
        if (consume) begin
          core_trans_ready_o = 1'b1;
        end else begin
          mpu_trans_valid_o  = core_trans_valid_i && !full;
          core_trans_ready_o = mpu_trans_ready_i && !full;
        end
      end
      WPT_RESP: begin
        // Nothing is in flight here, so the synthetic response owns the response port.
        core_resp_valid_o      = 1'b1;
        core_resp_o.bus_resp   = '0;
        core_resp_o.mpu_status = MPU_OK;
        core_resp_o.wpt_match  = match_q;
      end
      default: ;
    endcase
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(mpu_resp_valid_i && (cnt_q == '0)));

endmodule

// File: tb/tb_cv32e40s_wpt_tagged.sv
// Directed bench for cv32e40s_wpt_tagged with 4 triggers and 2 outstanding transfers.
module tb_cv32e40s_wpt_tagged;
  import cv32e40s_pkg::*;

  localparam int NT = 4;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NT-1:0] trigger_match, trigger_after;
  logic          core_trans_valid, core_trans_ready, core_trans_pushpop;
  obi_data_req_t core_trans, mpu_trans;
  logic          core_resp_valid;
  data_resp_t    core_resp, mpu_resp;
  logic          mpu_trans_valid, mpu_trans_ready, mpu_trans_pushpop;
  logic          mpu_resp_valid, core_wpt_wait;
  logic [31:0]   core_wpt_match;
  logic [$clog2(MO+1)-1:0] outstanding_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e40s_wpt_tagged #(
    .DBG_NUM_TRIGGERS (NT),
    .MAX_OUTSTANDING  (MO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .trigger_match_i      (trigger_match),
    .trigger_after_i      (trigger_after),
    .core_trans_valid_i   (core_trans_valid),
    .core_trans_ready_o   (core_trans_ready),
    .core_trans_i         (core_trans),
    .core_trans_pushpop_i (core_trans_pushpop),
    .core_resp_valid_o    (core_resp_valid),
    .core_resp_o          (core_resp),
    .mpu_trans_valid_o    (mpu_trans_valid),
    .mpu_trans_ready_i    (mpu_trans_ready),
    .mpu_trans_o          (mpu_trans),
    .mpu_trans_pushpop_o  (mpu_trans_pushpop),
    .mpu_resp_valid_i     (mpu_resp_valid),
    .mpu_resp_i           (mpu_resp),
    .core_wpt_wait_i      (core_wpt_wait),
    .core_wpt_match_o     (core_wpt_match),
    .outstanding_cnt_o    (outstanding_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Idle inputs carry junk on the response payload so zeroing of synthetic responses is visible.
  task automatic idle();
    core_trans_valid           = 1'b0;
    core_trans                 = '0;
    core_trans_pushpop         = 1'b0;
    trigger_match              = '0;
    trigger_after              = '0;
    core_wpt_wait              = 1'b1;
    mpu_resp_valid             = 1'b0;
    mpu_resp                   = '0;
    mpu_resp.bus_resp.rdata    = 32'hDEAD_BEEF;
    mpu_resp.mpu_status        = MPU_RE_FAULT;
  endtask

  task automatic req(input logic [31:0] addr, input logic we, input logic [NT-1:0] m,
                     input logic [NT-1:0] a);
    core_trans_valid = 1'b1;
    core_trans       = '0;
    core_trans.addr  = addr;
    core_trans.we    = we;
    core_trans.be    = 4'hF;
    trigger_match    = m;
    trigger_after    = a;
    $display("txn req  addr=0x%08h we=%0d match=0x%0h after=0x%0h wait=%0d", addr, we, m, a,
             core_wpt_wait);
  endtask

  task automatic resp(input logic [31:0] rdata);
    mpu_resp_valid          = 1'b1;
    mpu_resp                = '0;
    mpu_resp.bus_resp.rdata = rdata;
    mpu_resp.mpu_status     = MPU_OK;
    $display("txn resp rdata=0x%08h", rdata);
  endtask

  initial begin
    idle();
    mpu_trans_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 32'(outstanding_cnt), 0);
    check("rst_resp_valid", 32'(core_resp_valid), 0);
    check("rst_ready_follows1", 32'(core_trans_ready), 1);
    mpu_trans_ready = 1'b0;
    settle();
    check("rst_ready_follows0", 32'(core_trans_ready), 0);
    mpu_trans_ready = 1'b1;
    core_trans_valid = 1'b1;
    settle();
    check("rst_mpu_valid_fwd", 32'(mpu_trans_valid), 1);
    trigger_match = 4'h1;
    settle();
    check("rst_mpu_valid_before", 32'(mpu_trans_valid), 0);
    idle();
    rst_n = 1'b1;
    tick();

    // Before-hit with wait and nothing in flight: response the next cycle.
    req(32'h100, 1'b0, 4'h1, 4'h0);
    settle();
    check("a_ready", 32'(core_trans_ready), 1);
    check("a_mpu_valid", 32'(mpu_trans_valid), 0);
    check("a_wpt_match_o", core_wpt_match, 32'h1);
    tick();
    idle();
    settle();
    check("a_resp_valid", 32'(core_resp_valid), 1);
    check("a_resp_match", core_resp.wpt_match, 32'h1);
    check("a_resp_rdata", core_resp.bus_resp.rdata, 0);
    check("a_resp_status", 32'(core_resp.mpu_status), 0);
    tick();
    check("a_resp_done", 32'(core_resp_valid), 0);
    check("a_back_idle", 32'(core_trans_ready), 1);

    // Mixed classes: only the before bits are reported, the after bit is dropped.
    req(32'h104, 1'b0, 4'h3, 4'h2);
    settle();
    check("a2_mpu_valid", 32'(mpu_trans_valid), 0);
    tick();
    idle();
    settle();
    check("a2_resp_match", core_resp.wpt_match, 32'h1);
    tick();

    // After-hit on a store: forwarded, response tagged; next untagged transfer returns 0.
    req(32'h200, 1'b1, 4'h2, 4'h2);
    settle();
    check("c_mpu_valid", 32'(mpu_trans_valid), 1);
    check("c_ready", 32'(core_trans_ready), 1);
    check("c_mpu_addr", mpu_trans.addr, 32'h200);
    check("c_mpu_we", 32'(mpu_trans.we), 1);
    tick();
    req(32'h204, 1'b1, 4'h0, 4'h0);
    settle();
    check("c2_mpu_valid", 32'(mpu_trans_valid), 1);
    tick();
    idle();
    settle();
    check("c_cnt2", 32'(outstanding_cnt), 2);
    resp(32'hAA);
    settle();
    check("c_resp1_valid", 32'(core_resp_valid), 1);
    check("c_resp1_tag", core_resp.wpt_match, 32'h2);
    check("c_resp1_rdata", core_resp.bus_resp.rdata, 32'hAA);
    tick();
    resp(32'hBB);
    settle();
    check("c_resp2_tag", core_resp.wpt_match, 32'h0);
    check("c_resp2_rdata", core_resp.bus_resp.rdata, 32'hBB);
    tick();
    idle();
    settle();
    check("c_cnt0", 32'(outstanding_cnt), 0);

    // Two loads in flight, then a before-hit that must wait for both responses.
    req(32'h300, 1'b0, 4'h0, 4'h0);
    tick();
    req(32'h304, 1'b0, 4'h0, 4'h0);
    tick();
    req(32'h308, 1'b0, 4'h4, 4'h0);
    settle();
    check("b_cnt2", 32'(outstanding_cnt), 2);
    check("b_consume_ready", 32'(core_trans_ready), 1);
    check("b_consume_mpu", 32'(mpu_trans_valid), 0);
    tick();
    req(32'h30C, 1'b0, 4'h0, 4'h0);
    resp(32'h11);
    settle();
    check("b_wait_ready", 32'(core_trans_ready), 0);
    check("b_wait_mpu", 32'(mpu_trans_valid), 0);
    check("b_resp1_valid", 32'(core_resp_valid), 1);
    check("b_resp1_tag", core_resp.wpt_match, 32'h0);
    tick();
    mpu_resp_valid = 1'b0;
    settle();
    check("b_wait_noresp", 32'(core_resp_valid), 0);
    check("b_cnt1", 32'(outstanding_cnt), 1);
    check("b_wait_ready2", 32'(core_trans_ready), 0);
    tick();
    resp(32'h22);
    settle();
    check("b_wait_ready3", 32'(core_trans_ready), 0);
    tick();
    mpu_resp_valid = 1'b0;
    settle();
    check("b_syn_valid", 32'(core_resp_valid), 1);
    check("b_syn_match", core_resp.wpt_match, 32'h4);
    check("b_resp_ready", 32'(core_trans_ready), 0);
    check("b_resp_mpu", 32'(mpu_trans_valid), 0);
    check("b_cnt0", 32'(outstanding_cnt), 0);
    core_trans_valid = 1'b0;
    tick();
    check("b_done", 32'(core_resp_valid), 0);
    check("b_idle_ready", 32'(core_trans_ready), 1);

    // Back-to-back requests with delayed responses: the third stalls while full.
    idle();
    req(32'h400, 1'b0, 4'h0, 4'h0);
    tick();
    req(32'h404, 1'b0, 4'h0, 4'h0);
    tick();
    req(32'h408, 1'b0, 4'h0, 4'h0);
    settle();
    check("d_cnt_full", 32'(outstanding_cnt), 2);
    check("d_stall_mpu", 32'(mpu_trans_valid), 0);
    check("d_stall_ready", 32'(core_trans_ready), 0);
    tick();
    resp(32'h33);
    settle();
    check("d_no_bypass", 32'(mpu_trans_valid), 0);
    check("d_cnt_still2", 32'(outstanding_cnt), 2);
    tick();
    mpu_resp_valid = 1'b0;
    settle();
    check("d_cnt1", 32'(outstanding_cnt), 1);
    check("d_third_goes", 32'(mpu_trans_valid), 1);
    tick();
    core_trans_valid = 1'b0;
    settle();
    check("d_cnt_back2", 32'(outstanding_cnt), 2);
    resp(32'h34);
    tick();
    resp(32'h35);
    tick();
    idle();
    settle();
    check("d_drained", 32'(outstanding_cnt), 0);

    // Before-hit without wait: consumed, reported combinationally, no synthetic response.
    core_wpt_wait = 1'b0;
    req(32'h500, 1'b0, 4'h8, 4'h0);
    settle();
    check("e_ready", 32'(core_trans_ready), 1);
    check("e_mpu_valid", 32'(mpu_trans_valid), 0);
    check("e_wpt_match_o", core_wpt_match, 32'h8);
    tick();
    idle();
    settle();
    check("e_no_resp", 32'(core_resp_valid), 0);
    check("e_idle_ready", 32'(core_trans_ready), 1);
    tick();
    check("e_no_resp2", 32'(core_resp_valid), 0);

    // Reset while waiting: response dropped and stale tag flushed.
    req(32'h600, 1'b0, 4'h1, 4'h1);
    settle();
    check("f_fwd", 32'(mpu_trans_valid), 1);
    tick();
    req(32'h604, 1'b0, 4'h2, 4'h0);
    settle();
    check("f_consume", 32'(core_trans_ready), 1);
    tick();
    idle();
    settle();
    check("f_wait_ready", 32'(core_trans_ready), 0);
    check("f_cnt1", 32'(outstanding_cnt), 1);
    rst_n = 1'b0;
    settle();
    check("f_rst_cnt", 32'(outstanding_cnt), 0);
    check("f_rst_resp", 32'(core_resp_valid), 0);
    check("f_rst_ready", 32'(core_trans_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("f_post_noresp", 32'(core_resp_valid), 0);
    req(32'h608, 1'b0, 4'h0, 4'h0);
    tick();
    idle();
    resp(32'h44);
    settle();
    check("f_flushed_tag", core_resp.wpt_match, 32'h0);
    check("f_resp_valid", 32'(core_resp_valid), 1);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
